// File: rtl/pipeline_pkg.sv
// Shared encodings for the fetch sequencer: FSM states, branch opcodes, counter width.
package pipeline_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StWaitBr   = 2'd2,
    StRedirect = 2'd3
  } state_e;

  // Primary opcode field instr[31:26] values that count as control transfers.
  localparam logic [5:0] OpBeq = 6'b000100;
  localparam logic [5:0] OpBne = 6'b000101;
  localparam logic [5:0] OpJ   = 6'b000010;

  // Wide enough for the largest legal branch timeout (15).
  localparam int unsigned CntW = 4;

  function automatic logic is_branch_op(input logic [5:0] op);
    return (op == OpBeq) || (op == OpBne) || (op == OpJ);
  endfunction

endpackage

// File: rtl/branch_decode.sv
// Combinational branch detect on the primary opcode of a freshly fetched word.
module branch_decode
  import pipeline_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic       instr_valid_i,
  output logic       is_branch_o
);

  // Only a valid fetch can start a branch wait.
  always_comb begin
    is_branch_o = instr_valid_i && is_branch_op(opcode_i);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: drives PC enable/select and bubble insertion around branches,
// waits for the execute stage to resolve each branch, and flags unresolved branches.
module fetch_sequencer
  import pipeline_pkg::*;
#(
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned BR_TIMEOUT = 4   // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  input  logic              stall_req,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  input  logic [ADDR_W-1:0] resolve_target,
  output logic              pc_enable,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] pc_target,
  output logic              bubble,
  output logic              busy,
  output logic              br_timeout
);

  localparam logic [CntW-1:0] BrTimeoutCnt = CntW'(BR_TIMEOUT);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              pc_enable_q, pc_enable_d;
  logic              pc_sel_q, pc_sel_d;
  logic [ADDR_W-1:0] pc_target_q, pc_target_d;
  logic              bubble_q, bubble_d;
  logic              busy_q, busy_d;
  logic              br_timeout_q, br_timeout_d;
  logic              is_branch;

  // Only the opcode field matters here; the rest of the word is consumed downstream.
  logic unused_instr;
  assign unused_instr = ^instr[25:0];

  branch_decode u_branch_decode (
    .opcode_i      (instr[31:26]),
    .instr_valid_i (instr_valid),
    .is_branch_o   (is_branch)
  );

  // Next state and next registered outputs; outputs describe the current state's action.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_enable_d  = 1'b0;
    pc_sel_d     = 1'b0;
    pc_target_d  = pc_target_q;
    bubble_d     = 1'b0;
    busy_d       = busy_q;
    br_timeout_d = br_timeout_q;

    unique case (state_q)
      StIdle: begin
        bubble_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = StRun;
      end

      StRun: begin
        busy_d = 1'b0;
        // Stall wins over branch detect; fetch holds instr so the branch is seen again.
        if (stall_req) begin
          state_d = StRun;
        end else if (is_branch) begin
          state_d = StWaitBr;
          cnt_d   = BrTimeoutCnt;
          busy_d  = 1'b1;
        end else begin
          pc_enable_d = 1'b1;
        end
      end

      StWaitBr: begin
        bubble_d = 1'b1;
        cnt_d    = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        // A resolve arriving on the expiry cycle takes precedence over the timeout.
        if (resolve_valid) begin
          if (resolve_taken) begin
            pc_target_d = resolve_target;
            state_d     = StRedirect;
          end else begin
            state_d = StRun;
            busy_d  = 1'b0;
          end
        end else if (cnt_q <= 1) begin
          br_timeout_d = 1'b1;
          state_d      = StRun;
          busy_d       = 1'b0;
        end
      end

      StRedirect: begin
        pc_sel_d    = 1'b1;
        pc_enable_d = 1'b1;
        bubble_d    = 1'b1;
        busy_d      = 1'b0;
        state_d     = StRun;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counter and all outputs; reset aborts any outstanding branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      pc_enable_q  <= 1'b0;
      pc_sel_q     <= 1'b0;
      pc_target_q  <= '0;
      bubble_q     <= 1'b0;
      busy_q       <= 1'b0;
      br_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_enable_q  <= pc_enable_d;
      pc_sel_q     <= pc_sel_d;
      pc_target_q  <= pc_target_d;
      bubble_q     <= bubble_d;
      busy_q       <= busy_d;
      br_timeout_q <= br_timeout_d;
    end
  end

  assign pc_enable  = pc_enable_q;
  assign pc_sel     = pc_sel_q;
  assign pc_target  = pc_target_q;
  assign bubble     = bubble_q;
  assign busy       = busy_q;
  assign br_timeout = br_timeout_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, free run, taken/not-taken branches,
// stall priority, timeout, resolve-vs-expiry and reset mid-branch.
module tb_fetch_sequencer;

  localparam int unsigned AddrW = 7;

  logic             clk;
  logic             rst;
  logic [31:0]      instr;
  logic             instr_valid;
  logic             stall_req;
  logic             resolve_valid;
  logic             resolve_taken;
  logic [AddrW-1:0] resolve_target;
  logic             pc_enable;
  logic             pc_sel;
  logic [AddrW-1:0] pc_target;
  logic             bubble;
  logic             busy;
  logic             br_timeout;

  int tests_run;
  int tests_failed;

  fetch_sequencer #(
    .ADDR_W     (AddrW),
    .BR_TIMEOUT (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .stall_req      (stall_req),
    .resolve_valid  (resolve_valid),
    .resolve_taken  (resolve_taken),
    .resolve_target (resolve_target),
    .pc_enable      (pc_enable),
    .pc_sel         (pc_sel),
    .pc_target      (pc_target),
    .bubble         (bubble),
    .busy           (busy),
    .br_timeout     (br_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle ordered {pc_enable, pc_sel, bubble, busy, br_timeout}.
  logic [4:0] outs;
  assign outs = {pc_enable, pc_sel, bubble, busy, br_timeout};

  localparam logic [31:0] InstrBeq = {6'b000100, 26'h0000123};
  localparam logic [31:0] InstrBne = {6'b000101, 26'h0000456};
  localparam logic [31:0] InstrJ   = {6'b000010, 26'h0000789};
  localparam logic [31:0] InstrAdd = {6'b000000, 26'h0abcdef};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [4:0] exp);
    check_eq(tag, {27'b0, outs}, {27'b0, exp});
  endtask

  task automatic expect_tgt(input string tag, input logic [AddrW-1:0] exp);
    check_eq(tag, {25'b0, pc_target}, {25'b0, exp});
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst            = 1'b0;
    instr          = InstrAdd;
    instr_valid    = 1'b0;
    stall_req      = 1'b0;
    resolve_valid  = 1'b0;
    resolve_taken  = 1'b0;
    resolve_target = '0;

    #3;
    expect_out("reset_outs", 5'b00000);
    expect_tgt("reset_tgt", 7'h00);

    @(negedge clk);
    rst = 1'b1;
    step();
    expect_out("idle_outs", 5'b00100);
    step();
    expect_out("run_first", 5'b10000);
    instr_valid = 1'b1;  // non-branch fetch
    step();
    expect_out("run_free", 5'b10000);

    // beq, taken, resolved two cycles after fetch.
    instr = InstrBeq;
    step();
    expect_out("beq_detect", 5'b00010);
    instr_valid = 1'b0;
    step();
    expect_out("beq_wait1", 5'b00110);
    resolve_valid  = 1'b1;
    resolve_taken  = 1'b1;
    resolve_target = 7'h25;
    step();
    expect_out("beq_wait2", 5'b00110);
    expect_tgt("beq_capture", 7'h25);
    resolve_valid = 1'b0;
    step();
    expect_out("beq_redirect", 5'b11100);
    expect_tgt("beq_redir_tgt", 7'h25);
    step();
    expect_out("beq_run", 5'b10000);

    // Resolve outside WAIT_BR is ignored and pc_target holds.
    resolve_valid  = 1'b1;
    resolve_taken  = 1'b1;
    resolve_target = 7'h11;
    step();
    expect_out("stray_resolve", 5'b10000);
    expect_tgt("stray_tgt_hold", 7'h25);
    resolve_valid = 1'b0;

    // bne, not taken, resolved next cycle.
    instr       = InstrBne;
    instr_valid = 1'b1;
    step();
    expect_out("bne_detect", 5'b00010);
    instr_valid    = 1'b0;
    resolve_valid  = 1'b1;
    resolve_taken  = 1'b0;
    resolve_target = 7'h03;
    step();
    expect_out("bne_wait", 5'b00100);
    resolve_valid = 1'b0;
    step();
    expect_out("bne_run", 5'b10000);
    expect_tgt("bne_tgt_hold", 7'h25);

    // Stall held for three cycles alongside a beq fetch.
    instr       = InstrBeq;
    instr_valid = 1'b1;
    stall_req   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("stall_%0d", i), 5'b00000);
    end
    stall_req = 1'b0;
    step();
    expect_out("stall_release", 5'b00010);
    instr_valid   = 1'b0;
    resolve_valid = 1'b1;
    resolve_taken = 1'b0;
    step();
    expect_out("stall_wait", 5'b00100);
    resolve_valid = 1'b0;
    step();
    expect_out("stall_run", 5'b10000);

    // Resolve arrives on the very cycle the counter expires: resolve wins.
    instr       = InstrJ;
    instr_valid = 1'b1;
    step();
    expect_out("race_detect", 5'b00010);
    instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("race_wait_%0d", i), 5'b00110);
    end
    resolve_valid  = 1'b1;
    resolve_taken  = 1'b1;
    resolve_target = 7'h7f;
    step();
    expect_out("race_last", 5'b00110);
    expect_tgt("race_tgt", 7'h7f);
    resolve_valid = 1'b0;
    step();
    expect_out("race_redirect", 5'b11100);
    step();
    expect_out("race_run", 5'b10000);

    // j with no resolve: timeout after four bubbles; stall ignored while waiting.
    instr       = InstrJ;
    instr_valid = 1'b1;
    step();
    expect_out("tmo_detect", 5'b00010);
    instr_valid = 1'b0;
    stall_req   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("tmo_wait_%0d", i), 5'b00110);
    end
    step();
    expect_out("tmo_expire", 5'b00101);
    stall_req = 1'b0;
    step();
    expect_out("tmo_run", 5'b10001);
    step();
    expect_out("tmo_sticky", 5'b10001);

    // Reset asserted mid WAIT_BR aborts the branch.
    instr       = InstrBeq;
    instr_valid = 1'b1;
    step();
    expect_out("rstmid_detect", 5'b00011);
    instr_valid = 1'b0;
    step();
    expect_out("rstmid_wait", 5'b00111);
    rst = 1'b0;
    #1;
    expect_out("rstmid_async", 5'b00000);
    expect_tgt("rstmid_tgt", 7'h00);
    @(negedge clk);
    rst            = 1'b1;
    resolve_valid  = 1'b1;
    resolve_taken  = 1'b1;
    resolve_target = 7'h55;
    step();
    expect_out("rstmid_idle", 5'b00100);
    step();
    expect_out("rstmid_run1", 5'b10000);
    step();
    expect_out("rstmid_run2", 5'b10000);
    expect_tgt("rstmid_no_redir", 7'h00);
    resolve_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 7, PC/branch-target width.
REQ-002 Parameter BR_TIMEOUT, default 4, max cycles in WAIT_BR before timeout; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-005 instr  input  32  instruction word from instruction memory.
REQ-006 instr_valid  input  1  instr holds a newly fetched word this cycle.
REQ-007 stall_req  input  1  downstream hazard; hold PC, no bubble.
REQ-008 resolve_valid  input  1  execute stage reports branch outcome this cycle.
REQ-009 resolve_taken  input  1  outcome: 1 = taken; meaningful only with resolve_valid.
REQ-010 resolve_target  input  ADDR_W  branch target address; meaningful only with resolve_valid.
REQ-011 pc_enable  output  1  PC increment enable to fetch stage.
REQ-012 pc_sel  output  1  PC mux select: 1 = load pc_target, 0 = incremented PC.
REQ-013 pc_target  output  ADDR_W  redirect address.
REQ-014 bubble  output  1  insert NOP into fetch/decode latch this cycle.
REQ-015 busy  output  1  a branch is outstanding.
REQ-016 br_timeout  output  1  sticky error: branch unresolved within BR_TIMEOUT.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, WAIT_BR, REDIRECT; all outputs SHALL be registered (1-cycle latency from inputs).
REQ-018 Branch decode: instr[31:26] in {6'b000100 beq, 6'b000101 bne, 6'b000010 j} with instr_valid=1 SHALL count as a branch.
REQ-019 IDLE: pc_enable=0, bubble=1; next state unconditionally RUN.
REQ-020 RUN: pc_enable=1, bubble=0, pc_sel=0 unless stall_req or branch detected.
REQ-021 RUN with stall_req=1: pc_enable=0, bubble=0, state held; stall SHALL take priority over branch detect in the same cycle (branch re-evaluated next cycle, instr held by fetch).
REQ-022 RUN with branch detected and stall_req=0: go WAIT_BR, load timeout counter with BR_TIMEOUT, busy=1.
REQ-023 WAIT_BR: pc_enable=0, bubble=1 each cycle; counter decrements each cycle; stall_req SHALL be ignored.
REQ-024 WAIT_BR with resolve_valid=1, resolve_taken=1: capture resolve_target into pc_target, go REDIRECT.
REQ-025 WAIT_BR with resolve_valid=1, resolve_taken=0: go RUN, busy=0.
REQ-026 WAIT_BR with counter reaching 0 and no resolve_valid: set br_timeout=1, go RUN, busy=0.
REQ-027 resolve_valid and counter expiry in the same cycle: resolve SHALL win; br_timeout unchanged.
REQ-028 REDIRECT: exactly one cycle with pc_sel=1, pc_enable=1, bubble=1; then RUN, busy=0.
REQ-029 resolve_valid outside WAIT_BR SHALL be ignored (no state or output change).
REQ-030 br_timeout SHALL remain 1 until reset.
REQ-031 pc_target SHALL hold its last captured value outside REDIRECT.

Reset
REQ-032 On rst=0, immediately: state=IDLE, pc_enable=0, pc_sel=0, pc_target=0, bubble=0, busy=0, br_timeout=0, counter=0.
REQ-033 Reset asserted mid-branch (WAIT_BR/REDIRECT) SHALL abort it; no redirect issued after release.
REQ-034 First rising edge after rst deasserts SHALL move to IDLE outputs; second to RUN.

Structure
REQ-035 State encoding and branch opcode constants SHALL live in shared package pipeline_pkg.
REQ-036 One sub-module is natural: branch_decode (combinational opcode match), instantiated once.

Verification
REQ-037 Reset then free run, no branches -> pc_enable=1 from 2nd cycle after release, bubble=0 thereafter.
REQ-038 beq fetched, resolve_valid=1/taken=1/target=7'h25 two cycles later -> 2 bubble cycles, then one cycle pc_sel=1, pc_target=7'h25, then RUN.
REQ-039 bne fetched, resolved not-taken next cycle -> one bubble cycle, pc_sel never 1, back to RUN.
REQ-040 j fetched, no resolve for BR_TIMEOUT=4 cycles -> 4 bubble cycles, br_timeout=1 sticky, RUN resumes.
REQ-041 stall_req=1 concurrent with beq fetch for 3 cycles -> pc_enable=0, bubble=0 for 3 cycles, then WAIT_BR entered.
REQ-042 rst=0 asserted during WAIT_BR -> outputs zero immediately; resolve_valid after release ignored, no pc_sel pulse.
